// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter in front of a shared synchronous FIFO.
// Serializes single-word requests onto the FIFO write port, confirms each write
// against fifo_wr_ack, retries rejected words and pulses req_done once per stored word.
// Optional statistics counters are compiled in with `define FIFO_ARB_STATS_EN.
//
// Requester handshake: a requester raises req_valid[i] with its word on
// req_data[i*FIFO_WIDTH +: FIFO_WIDTH] and holds both until req_done[i] pulses
// for one cycle; that pulse means the FIFO has stored the word. During the
// req_done cycle the requester is masked from arbitration, so it may either drop
// req_valid or keep it high to present its next word.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         stat_grants,
    output logic [15:0]                   stat_retries
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d;
    logic [FIFO_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic                    fifo_wr_en_q, fifo_wr_en_d;
    logic [FIFO_WIDTH-1:0]   fifo_data_in_q, fifo_data_in_d;
    logic [NUM_REQ-1:0]      req_done_q, req_done_d;
    logic                    busy_q, busy_d;

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]   stat_grants_q, stat_grants_d;
    logic [15:0]             stat_retries_q, stat_retries_d;
`endif

    logic [NUM_REQ-1:0]      eligible;
    logic                    win_found;
    logic [ID_W-1:0]         win_id;
    logic [ID_W-1:0]         cand;
    logic [FIFO_WIDTH-1:0]   win_data;

    // Round-robin pick: first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
    // A requester whose req_done is high this cycle is masked so its stored word is not re-granted.
    always_comb begin
        eligible  = req_valid & ~req_done_q;
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign win_data = req_data[int'(win_id)*FIFO_WIDTH +: FIFO_WIDTH];

    // Next-state and next-output logic; every output is registered from its _d value.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        hold_data_d    = hold_data_q;
        fifo_wr_en_d   = 1'b0;
        fifo_data_in_d = '0;
        req_done_d     = '0;
`ifdef FIFO_ARB_STATS_EN
        stat_grants_d  = stat_grants_q;
        stat_retries_d = stat_retries_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found && !fifo_full) begin
                    hold_data_d    = win_data;
                    grant_id_d     = win_id;
                    fifo_wr_en_d   = 1'b1;
                    fifo_data_in_d = win_data;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                // The write strobe was driven for this single cycle; the ack follows one cycle later.
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (fifo_wr_ack) begin
                    req_done_d[grant_id_q] = 1'b1;
                    rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    state_d  = IDLE;
`ifdef FIFO_ARB_STATS_EN
                    if (stat_grants_q[int'(grant_id_q)*16 +: 16] != 16'hFFFF) begin
                        stat_grants_d[int'(grant_id_q)*16 +: 16] =
                            stat_grants_q[int'(grant_id_q)*16 +: 16] + 16'd1;
                    end
`endif
                end else begin
                    // Word was dropped by a full FIFO: keep the latched word and winner for a retry.
                    state_d = HOLD;
`ifdef FIFO_ARB_STATS_EN
                    if (stat_retries_q != 16'hFFFF) begin
                        stat_retries_d = stat_retries_q + 16'd1;
                    end
`endif
                end
            end
            HOLD: begin
                if (!fifo_full) begin
                    fifo_wr_en_d   = 1'b1;
                    fifo_data_in_d = hold_data_q;
                    state_d        = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight word without a req_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            hold_data_q    <= '0;
            fifo_wr_en_q   <= 1'b0;
            fifo_data_in_q <= '0;
            req_done_q     <= '0;
            busy_q         <= 1'b0;
`ifdef FIFO_ARB_STATS_EN
            stat_grants_q  <= '0;
            stat_retries_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            hold_data_q    <= hold_data_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
            fifo_data_in_q <= fifo_data_in_d;
            req_done_q     <= req_done_d;
            busy_q         <= busy_d;
`ifdef FIFO_ARB_STATS_EN
            stat_grants_q  <= stat_grants_d;
            stat_retries_q <= stat_retries_d;
`endif
        end
    end

    assign req_done     = req_done_q;
    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_data_in = fifo_data_in_q;
    assign busy         = busy_q;
    assign grant_id     = grant_id_q;
`ifdef FIFO_ARB_STATS_EN
    assign stat_grants  = stat_grants_q;
    assign stat_retries = stat_retries_q;
`endif

endmodule
